// File: rtl/ddr_arbiter.sv
// Round-robin arbiter sharing one DDR line port between two cache-line requesters.
// Each request runs an optional writeback and then a refill read; same-line misses share one read.
module ddr_arbiter #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 128
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*ADDR_W-1:0]   req_raddr,
    input  logic [1:0]            req_wb,
    input  logic [2*ADDR_W-1:0]   req_waddr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            resp_valid,
    output logic [DATA_W-1:0]     resp_data,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_avalid,
    input  logic                  rd_aready,
    input  logic [DATA_W-1:0]     rd_data,
    input  logic                  rd_valid,
    output logic                  rd_dready
);

    typedef enum logic [2:0] {IDLE, WB_REQ, WB_WAIT, RD_REQ, RD_DATA, RESP} state_t;

    state_t              state, state_nxt;
    logic                rr_ptr;
    logic                gnt;
    logic                share;
    logic [ADDR_W-1:0]   raddr_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                any_req;
    logic                g;
    logic                other;
    logic                coalesce;
    logic [ADDR_W-1:0]   g_raddr;
    logic [ADDR_W-1:0]   o_raddr;
    logic [ADDR_W-1:0]   g_waddr;
    logic [DATA_W-1:0]   g_wdata;

    // The favoured requester wins if it is asking; otherwise the other one does.
    assign any_req  = |req_valid;
    assign g        = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
    assign other    = ~g;
    assign g_raddr  = g ? req_raddr[2*ADDR_W-1:ADDR_W] : req_raddr[ADDR_W-1:0];
    assign o_raddr  = g ? req_raddr[ADDR_W-1:0]        : req_raddr[2*ADDR_W-1:ADDR_W];
    assign g_waddr  = g ? req_waddr[2*ADDR_W-1:ADDR_W] : req_waddr[ADDR_W-1:0];
    assign g_wdata  = g ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    // A second requester that needs its own writeback cannot ride along on this read.
    assign coalesce = req_valid[other] && (o_raddr == g_raddr) && !req_wb[other];

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        resp_valid = '0;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        rd_avalid  = 1'b0;
        rd_addr    = '0;
        rd_dready  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    req_ready[g] = 1'b1;
                    if (coalesce) req_ready[other] = 1'b1;
                    state_nxt = req_wb[g] ? WB_REQ : RD_REQ;
                end
            end
            WB_REQ: begin
                wr_valid = 1'b1;
                wr_addr  = waddr_q;
                wr_data  = wdata_q;
                if (wr_ready) state_nxt = WB_WAIT;
            end
            WB_WAIT: begin
                if (wr_ready) state_nxt = RD_REQ;
            end
            RD_REQ: begin
                rd_avalid = 1'b1;
                rd_addr   = raddr_q;
                if (rd_aready) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                rd_dready = 1'b1;
                if (rd_valid) state_nxt = RESP;
            end
            RESP: begin
                resp_valid[gnt] = 1'b1;
                if (share) resp_valid[~gnt] = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            gnt       <= 1'b0;
            share     <= 1'b0;
            raddr_q   <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            resp_data <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                gnt     <= g;
                rr_ptr  <= other;
                share   <= coalesce;
                raddr_q <= g_raddr;
                waddr_q <= g_waddr;
                wdata_q <= g_wdata;
            end
            if (state == RD_DATA && rd_valid) resp_data <= rd_data;
            if (state == RESP) share <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ddr_arbiter.sv
// Bench for ddr_arbiter: requester engine, randomized DDR responder, and a transaction-level
// reference model that predicts grants, DDR traffic and refill responses.
module tb_ddr_arbiter;

    localparam int AW = 27;
    localparam int DW = 128;

    typedef struct packed {
        logic [AW-1:0] raddr;
        logic          wb;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
    } req_t;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_ready;
    logic [2*AW-1:0] req_raddr = '0;
    logic [1:0]      req_wb = '0;
    logic [2*AW-1:0] req_waddr = '0;
    logic [2*DW-1:0] req_wdata = '0;
    logic [1:0]      resp_valid;
    logic [DW-1:0]   resp_data;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            wr_valid;
    logic            wr_ready = 1'b0;
    logic [AW-1:0]   rd_addr;
    logic            rd_avalid;
    logic            rd_aready = 1'b0;
    logic [DW-1:0]   rd_data = '0;
    logic            rd_valid = 1'b0;
    logic            rd_dready;

    ddr_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_raddr(req_raddr),
        .req_wb(req_wb), .req_waddr(req_waddr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_addr(rd_addr), .rd_avalid(rd_avalid), .rd_aready(rd_aready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_dready(rd_dready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard queues: refill data per requester, expected DDR writes and reads.
    logic [DW-1:0]    exp_q0[$];
    logic [DW-1:0]    exp_q1[$];
    logic [AW+DW-1:0] exp_wr_q[$];
    logic [AW-1:0]    exp_rd_q[$];
    req_t             pend_q0[$];
    req_t             pend_q1[$];

    int   rs[2];
    int   gap = 0;
    int   rd_lat_min = 0;
    int   rd_lat_max = 4;
    logic stray_go = 1'b0;
    int   wb_grants = 0;
    int   wr_completes = 0;
    logic m_busy = 1'b0;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory contents seen by refills; 0x120 carries the recognisable A5 pattern.
    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        logic [31:0] h;
        if (a == 27'h0000120) return {16{8'hA5}};
        h = {5'd0, a} * 32'h9E37_79B1;
        return {h, ~h, h ^ 32'h1234_5678, {5'd0, a}};
    endfunction

    task automatic push(input int i, input logic [AW-1:0] ra, input logic wb,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        req_t r;
        r.raddr = ra;
        r.wb    = wb;
        r.waddr = wa;
        r.wdata = wd;
        if (i == 0) pend_q0.push_back(r);
        else        pend_q1.push_back(r);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((pend_q0.size() != 0 || pend_q1.size() != 0 || rs[0] != 0 || rs[1] != 0 || m_busy)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", n >= budget, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    // Requester engine: a requester holds req_valid until accepted, then waits for its refill.
    initial begin : req_engine
        req_t r;
        rs[0] = 0;
        rs[1] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rstn) rs[i] = 0;
                else if (rs[i] == 1 && req_ready[i]) rs[i] = 2;
                else if (rs[i] == 2 && resp_valid[i]) rs[i] = 0;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (!rstn) begin
                    req_valid[i] = 1'b0;
                end else begin
                    if (rs[i] == 2) req_valid[i] = 1'b0;
                    if (rs[i] == 0 && ((i == 0) ? pend_q0.size() : pend_q1.size()) != 0
                        && $urandom_range(0, gap) == 0) begin
                        if (i == 0) begin
                            r = pend_q0.pop_front();
                            exp_q0.push_back(data_of(r.raddr));
                        end else begin
                            r = pend_q1.pop_front();
                            exp_q1.push_back(data_of(r.raddr));
                        end
                        req_raddr[i*AW +: AW] = r.raddr;
                        req_wb[i]             = r.wb;
                        req_waddr[i*AW +: AW] = r.waddr;
                        req_wdata[i*DW +: DW] = r.wdata;
                        req_valid[i]          = 1'b1;
                        rs[i]                 = 1;
                    end
                end
            end
        end
    end

    // DDR responder with random accept/complete/data latencies.
    initial begin : ddr_model
        logic [AW+DW-1:0] e;
        logic [AW-1:0]    a;
        int               lat;
        forever begin
            @(negedge clk);
            if (stray_go) begin
                @(posedge clk);
                #1;
                rd_valid = 1'b1;
                rd_data  = {$urandom, $urandom, $urandom, $urandom};
                wr_ready = 1'b1;
                @(posedge clk);
                #1;
                rd_valid = 1'b0;
                wr_ready = 1'b0;
                wait (!stray_go);
            end else if (rstn && wr_valid) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                @(posedge clk);
                #1 wr_ready = 1'b1;
                @(negedge clk);
                check("wr_valid_held", wr_valid, 1'b1);
                if (exp_wr_q.size() == 0) begin
                    check("wr_unexpected", 1'b1, 1'b0);
                end else begin
                    e = exp_wr_q.pop_front();
                    check("wr_addr", wr_addr, e[AW+DW-1:DW]);
                    check("wr_data", wr_data, e[DW-1:0]);
                end
                @(posedge clk);
                #1 wr_ready = 1'b0;
                @(negedge clk);
                check("wr_drop", {wr_valid, rd_avalid}, 2'b00);
                repeat ($urandom_range(0, 4)) @(negedge clk);
                @(posedge clk);
                #1 wr_ready = 1'b1;
                @(posedge clk);
                #1 wr_ready = 1'b0;
                wr_completes++;
            end else if (rstn && rd_avalid) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                @(posedge clk);
                #1 rd_aready = 1'b1;
                @(negedge clk);
                check("rd_avalid_held", rd_avalid, 1'b1);
                a = rd_addr;
                if (exp_rd_q.size() == 0) check("rd_unexpected", 1'b1, 1'b0);
                else check("rd_addr", rd_addr, exp_rd_q.pop_front());
                @(posedge clk);
                #1 rd_aready = 1'b0;
                @(negedge clk);
                check("rd_dready", rd_dready, 1'b1);
                lat = $urandom_range(rd_lat_min, rd_lat_max);
                for (int k = 0; k < lat && rstn; k++) @(negedge clk);
                if (rstn) begin
                    @(posedge clk);
                    #1;
                    rd_valid = 1'b1;
                    rd_data  = data_of(a);
                    @(posedge clk);
                    #1 rd_valid = 1'b0;
                end
            end
        end
    end

    // Reference model: whenever no transfer is in flight, the pending requester that was
    // not served last wins; a same-line, no-writeback partner is served by the same read.
    initial begin : monitor
        logic          m_last;
        logic          m_beat;
        logic          m_issue;
        logic          m_issue_wb;
        logic [1:0]    m_mask;
        logic [1:0]    exp_rdy;
        logic          g;
        logic          o;
        logic [AW-1:0] ra_g;
        logic [AW-1:0] ra_o;
        m_last  = 1'b1;
        m_beat  = 1'b0;
        m_issue = 1'b0;
        m_issue_wb = 1'b0;
        m_mask  = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                check("rst_out", {req_ready, resp_valid, wr_valid, rd_avalid, rd_dready, wr_addr, rd_addr}, '0);
                check("rst_wdata", wr_data, '0);
                check("rst_rdata", resp_data, '0);
                m_busy  = 1'b0;
                m_last  = 1'b1;
                m_beat  = 1'b0;
                m_issue = 1'b0;
                exp_q0.delete();
                exp_q1.delete();
                exp_wr_q.delete();
                exp_rd_q.delete();
                wb_grants = wr_completes;
            end else begin
                exp_rdy = '0;
                g = 1'b0;
                if (!m_busy && req_valid != 2'b00) begin
                    if (req_valid == 2'b11) g = ~m_last;
                    else                    g = req_valid[1];
                    o = ~g;
                    ra_g = req_raddr[g*AW +: AW];
                    ra_o = req_raddr[o*AW +: AW];
                    exp_rdy[g] = 1'b1;
                    if (req_valid[o] && ra_o == ra_g && !req_wb[o]) exp_rdy[o] = 1'b1;
                end
                check("req_ready", req_ready, exp_rdy);
                check("resp_valid", resp_valid, m_beat ? m_mask : 2'b00);
                if (resp_valid[0]) begin
                    if (exp_q0.size() == 0) check("resp0_unexpected", 1'b1, 1'b0);
                    else check("resp_data0", resp_data, exp_q0.pop_front());
                end
                if (resp_valid[1]) begin
                    if (exp_q1.size() == 0) check("resp1_unexpected", 1'b1, 1'b0);
                    else check("resp_data1", resp_data, exp_q1.pop_front());
                end
                if (m_issue) check("issue_latency", {wr_valid, rd_avalid}, {m_issue_wb, ~m_issue_wb});
                if (!m_busy && !m_beat)
                    check("idle_out", {wr_valid, rd_avalid, rd_dready, wr_addr, rd_addr}, '0);
                if (wr_valid && rd_avalid) check("wr_rd_exclusive", 1'b1, 1'b0);
                if (rd_avalid) check("rd_after_wb", wb_grants == wr_completes, 1'b1);

                m_issue = 1'b0;
                if (m_beat) begin
                    m_beat = 1'b0;
                    m_busy = 1'b0;
                end
                if (exp_rdy != 2'b00) begin
                    m_busy     = 1'b1;
                    m_last     = g;
                    m_mask     = exp_rdy;
                    m_issue    = 1'b1;
                    m_issue_wb = req_wb[g];
                    exp_rd_q.push_back(req_raddr[g*AW +: AW]);
                    if (req_wb[g]) begin
                        exp_wr_q.push_back({req_waddr[g*AW +: AW], req_wdata[g*DW +: DW]});
                        wb_grants++;
                    end
                end
                if (rd_valid && rd_dready) m_beat = 1'b1;
            end
        end
    end

    initial begin : main
        int            n;
        logic [31:0]   t;
        logic [AW-1:0] pool[3];
        pool[0] = 27'h0000800;
        pool[1] = 27'h0000810;
        pool[2] = 27'h0001230;

        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rstn = 1'b1;
        repeat (2) @(negedge clk);

        push(0, 27'h0000120, 1'b0, '0, '0);
        wait_idle(200);

        push(1, 27'h0000200, 1'b1, 27'h0004560, {8{16'h1111}});
        wait_idle(200);

        push(0, 27'h0000100, 1'b0, '0, '0);
        push(0, 27'h0000110, 1'b0, '0, '0);
        push(1, 27'h0000300, 1'b0, '0, '0);
        push(1, 27'h0000310, 1'b0, '0, '0);
        wait_idle(400);

        push(0, 27'h0000800, 1'b0, '0, '0);
        push(1, 27'h0000800, 1'b0, '0, '0);
        wait_idle(200);
        push(0, 27'h0000800, 1'b0, '0, '0);
        push(1, 27'h0000800, 1'b1, 27'h0000900, {4{32'hDEAD_BEEF}});
        wait_idle(300);

        stray_go = 1'b1;
        repeat (6) @(negedge clk);
        stray_go = 1'b0;
        check("stray_resp_data", resp_data, data_of(27'h0000800));

        rd_lat_min = 40;
        rd_lat_max = 40;
        push(0, 27'h0000300, 1'b0, '0, '0);
        n = 0;
        while (!rd_dready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_rd_data", n < 100, 1'b1);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("async_rst_ctrl", {req_ready, resp_valid, wr_valid, rd_avalid, rd_dready}, '0);
        check("async_rst_rdata", resp_data, '0);
        repeat (3) @(negedge clk);
        rd_lat_min = 0;
        rd_lat_max = 4;
        @(posedge clk);
        #3 rstn = 1'b1;
        push(0, 27'h0000040, 1'b0, '0, '0);
        push(1, 27'h0000080, 1'b0, '0, '0);
        wait_idle(300);

        gap = 3;
        for (int k = 0; k < 120; k++) begin
            for (int i = 0; i < 2; i++) begin
                t = $urandom;
                push(i, pool[$urandom_range(0, 2)], ($urandom_range(0, 2) == 0),
                     {t[AW-1:4], 4'h0}, {$urandom, $urandom, $urandom, $urandom});
            end
        end
        wait_idle(20000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
